// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module   : instr_fetch_unit_if
// Purpose  : Instruction-memory request/acknowledge bus used by the fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage: owns the PC, fetches over req/ack into the IR, stops on HALT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  wire                      clk,
   input  wire                      reset_n,
   instr_fetch_unit_if.master       mem,
   input  wire                      stall_i,
   input  wire                      redirect_i,
   input  wire  [ADDR_W-1:0]        redir_off_i,
   output logic                     instr_valid_o,
   output logic [DATA_W-1:0]        instr_o,
   output logic [ADDR_W-1:0]        instr_pc_o,
   output logic [3:0]               opcode_o,
   output logic [11:0]              imm12_o,
   output logic                     halted_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_HOLD   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [DATA_W-1:0] c_halt_word = '1;
   localparam logic [ADDR_W-1:0] c_one       = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [DATA_W-1:0] instr_q;
   logic [ADDR_W-1:0] instr_pc_q;
   logic              mem_req_q;
   logic              instr_valid_q;
   logic              halted_q;

   // Next PC is always relative to the address the held word came from.
   always_comb begin
      pc_d = instr_pc_q + c_one;
      if (redirect_i) begin
         pc_d = instr_pc_q + redir_off_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         mem_req_q     <= 1'b0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q   <= S_FETCH;
               mem_req_q <= 1'b1;
            end
            S_FETCH: begin
               if (mem.mem_ack) begin
                  instr_q       <= mem.mem_rdata;
                  instr_pc_q    <= pc_q;
                  mem_req_q     <= 1'b0;
                  instr_valid_q <= 1'b1;
                  state_q       <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (!stall_i) begin
                  instr_valid_q <= 1'b0;
                  // HALT takes priority over any redirect offered with it.
                  if (instr_q == c_halt_word) begin
                     halted_q <= 1'b1;
                     state_q  <= S_HALTED;
                  end else begin
                     pc_q      <= pc_d;
                     mem_req_q <= 1'b1;
                     state_q   <= S_FETCH;
                  end
               end
            end
            default: begin
               state_q <= S_HALTED;
            end
         endcase
      end
   end

   assign mem.mem_req    = mem_req_q;
   assign mem.mem_addr   = pc_q;
   assign instr_valid_o  = instr_valid_q;
   assign instr_o        = instr_q;
   assign instr_pc_o     = instr_pc_q;
   assign opcode_o       = instr_q[15:12];
   assign imm12_o        = instr_q[11:0];
   assign halted_o       = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        redirect;
   logic [15:0] redir_off;
   logic        instr_valid;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic [3:0]  opcode;
   logic [11:0] imm12;
   logic        halted;

   int n_vec;
   int n_err;

   instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

   instr_fetch_unit #(
      .ADDR_W   (16),
      .DATA_W   (16),
      .RESET_PC (16'h0000)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .mem           (mem_if.master),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redir_off_i   (redir_off),
      .instr_valid_o (instr_valid),
      .instr_o       (instr),
      .instr_pc_o    (instr_pc),
      .opcode_o      (opcode),
      .imm12_o       (imm12),
      .halted_o      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // One rising edge, then sample on the following falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // From HOLD: accept (optionally redirecting), check the fetch address, then load next_word.
   task automatic adv(input logic r, input logic [15:0] off, input logic [15:0] exp_addr,
                      input logic [15:0] next_word);
      stall     = 1'b0;
      redirect  = r;
      redir_off = off;
      cyc();
      stall    = 1'b1;
      redirect = 1'b0;
      chk("adv_req", 32'(mem_if.mem_req), 32'd1);
      chk("adv_addr", 32'(mem_if.mem_addr), 32'(exp_addr));
      mem_if.mem_rdata = next_word;
      cyc();
      chk("adv_valid", 32'(instr_valid), 32'd1);
      chk("adv_ipc", 32'(instr_pc), 32'(exp_addr));
      chk("adv_instr", 32'(instr), 32'(next_word));
   endtask

   initial begin
      n_vec            = 0;
      n_err            = 0;
      reset_n          = 1'b0;
      stall            = 1'b0;
      redirect         = 1'b0;
      redir_off        = 16'h0000;
      mem_if.mem_ack   = 1'b1;
      mem_if.mem_rdata = 16'h1234;
      repeat (3) cyc();

      chk("rst_req", 32'(mem_if.mem_req), 32'd0);
      chk("rst_addr", 32'(mem_if.mem_addr), 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_instr", 32'(instr), 32'h0);
      chk("rst_ipc", 32'(instr_pc), 32'h0);

      // Ack tied high, no stall: alternate FETCH / HOLD.
      reset_n = 1'b1;
      cyc();
      chk("f0_req", 32'(mem_if.mem_req), 32'd1);
      chk("f0_addr", 32'(mem_if.mem_addr), 32'h0);
      cyc();
      chk("h0_valid", 32'(instr_valid), 32'd1);
      chk("h0_instr", 32'(instr), 32'h1234);
      chk("h0_opcode", 32'(opcode), 32'h1);
      chk("h0_imm12", 32'(imm12), 32'h234);
      chk("h0_ipc", 32'(instr_pc), 32'h0);
      chk("h0_req", 32'(mem_if.mem_req), 32'd0);
      cyc();
      chk("f1_req", 32'(mem_if.mem_req), 32'd1);
      chk("f1_addr", 32'(mem_if.mem_addr), 32'h1);
      chk("f1_valid", 32'(instr_valid), 32'd0);
      cyc();
      chk("h1_ipc", 32'(instr_pc), 32'h1);
      mem_if.mem_ack = 1'b0;
      cyc();
      chk("f2_req", 32'(mem_if.mem_req), 32'd1);
      chk("f2_addr", 32'(mem_if.mem_addr), 32'h2);

      // Delayed ack with changing read data.
      for (int i = 0; i < 3; i++) begin
         mem_if.mem_rdata = 16'hA000 + 16'(i);
         cyc();
         chk("wait_req", 32'(mem_if.mem_req), 32'd1);
         chk("wait_addr", 32'(mem_if.mem_addr), 32'h2);
         chk("wait_valid", 32'(instr_valid), 32'd0);
      end
      mem_if.mem_ack   = 1'b1;
      mem_if.mem_rdata = 16'h5ABC;
      stall            = 1'b1;
      cyc();
      chk("ack_valid", 32'(instr_valid), 32'd1);
      chk("ack_instr", 32'(instr), 32'h5ABC);
      chk("ack_ipc", 32'(instr_pc), 32'h2);

      // Stall with redirect and stray acks present: nothing moves.
      redirect         = 1'b1;
      redir_off        = 16'hFFF8;
      mem_if.mem_rdata = 16'h1111;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("stl_instr", 32'(instr), 32'h5ABC);
         chk("stl_ipc", 32'(instr_pc), 32'h2);
         chk("stl_valid", 32'(instr_valid), 32'd1);
         chk("stl_req", 32'(mem_if.mem_req), 32'd0);
      end
      redirect = 1'b0;
      stall    = 1'b0;
      cyc();
      chk("unstl_req", 32'(mem_if.mem_req), 32'd1);
      chk("unstl_addr", 32'(mem_if.mem_addr), 32'h3);
      stall            = 1'b1;
      mem_if.mem_rdata = 16'h2000;
      cyc();
      chk("h3_ipc", 32'(instr_pc), 32'h3);

      // PC-relative redirects and wrap-around.
      adv(1'b1, 16'h000D, 16'h0010, 16'h3000);
      adv(1'b1, 16'hFFF8, 16'h0008, 16'h3001);
      adv(1'b1, 16'h0008, 16'h0010, 16'h3002);
      adv(1'b1, 16'h0007, 16'h0017, 16'h3003);
      adv(1'b1, 16'hFFE8, 16'hFFFF, 16'h4000);
      adv(1'b0, 16'h0000, 16'h0000, 16'hFFFF);
      chk("halt_opcode", 32'(opcode), 32'hF);

      // HALT accepted alongside a redirect.
      stall     = 1'b0;
      redirect  = 1'b1;
      redir_off = 16'h0004;
      cyc();
      chk("hlt_halted", 32'(halted), 32'd1);
      chk("hlt_req", 32'(mem_if.mem_req), 32'd0);
      chk("hlt_valid", 32'(instr_valid), 32'd0);
      redirect         = 1'b0;
      mem_if.mem_rdata = 16'h1111;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("hlt_stay", 32'(halted), 32'd1);
         chk("hlt_req2", 32'(mem_if.mem_req), 32'd0);
         chk("hlt_instr", 32'(instr), 32'hFFFF);
         chk("hlt_valid2", 32'(instr_valid), 32'd0);
      end

      // Reset in the middle of a fetch with ack in the same cycle.
      reset_n = 1'b0;
      cyc();
      chk("rst2_halted", 32'(halted), 32'd0);
      reset_n        = 1'b1;
      mem_if.mem_ack = 1'b0;
      cyc();
      chk("rf_req", 32'(mem_if.mem_req), 32'd1);
      chk("rf_addr", 32'(mem_if.mem_addr), 32'h0);
      reset_n          = 1'b0;
      mem_if.mem_ack   = 1'b1;
      mem_if.mem_rdata = 16'h7777;
      cyc();
      chk("rf_instr", 32'(instr), 32'h0);
      chk("rf_ipc", 32'(instr_pc), 32'h0);
      chk("rf_valid", 32'(instr_valid), 32'd0);
      chk("rf_req2", 32'(mem_if.mem_req), 32'd0);
      chk("rf_addr2", 32'(mem_if.mem_addr), 32'h0);
      reset_n = 1'b1;
      cyc();
      cyc();
      chk("post_valid", 32'(instr_valid), 32'd1);
      chk("post_instr", 32'(instr), 32'h7777);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
